// File: rtl/isa_host_cmd.sv
// Host command front end for the ISA bus sequencer: assembles opcode/address/data
// bytes from a four-phase strobe/ack host link and drives the sequencer control word.
module isa_host_cmd #(
   parameter int ADDR_WIDTH     = 10,
   parameter int TIMEOUT_CYCLES = 255
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic [7:0]            host_data_in,
   input  logic                  host_strobe,
   output logic                  host_ack,
   output logic                  host_busy,
   output logic [7:0]            host_data_out,
   output logic                  error,
   output logic [7:0]            control_out,
   output logic [ADDR_WIDTH-1:0] address_out,
   output logic [7:0]            data_out,
   input  logic [7:0]            bus_data_in,
   input  logic                  data_read_n,
   input  logic                  control_reset_n,
   output logic [2:0]            state_dbg
);

   // Host link: host_strobe rises with a byte on host_data_in, host_ack rises once
   // the byte is taken, the host drops host_strobe, and host_ack then falls.

   typedef enum logic [2:0] {
      S_IDLE      = 3'd0,
      S_ADDR_LO   = 3'd1,
      S_ADDR_HI   = 3'd2,
      S_DATA      = 3'd3,
      S_ISSUE     = 3'd4,
      S_WAIT_DONE = 3'd5
   } state_t;

   localparam logic [7:0] TIMEOUT_LAST = 8'(TIMEOUT_CYCLES - 1);

   state_t     state, state_next;
   logic       strobe_s1, strobe_s2, strobe_d;
   logic       strobe_edge, capture;
   logic       op_read, op_write;
   logic       cmd_read;
   logic [7:0] timeout_cnt;
   logic       timeout_hit, cycle_done;

   assign strobe_edge = strobe_s2 & ~strobe_d;
   assign capture     = strobe_edge & ~host_busy;
   assign op_read     = (host_data_in == 8'h01);
   assign op_write    = (host_data_in == 8'h02);
   assign timeout_hit = (timeout_cnt == TIMEOUT_LAST);
   assign cycle_done  = ~control_reset_n;

   always_ff @(posedge clk) begin
      if (!reset) state <= S_IDLE;
      else        state <= state_next;
   end

   always_comb begin
      state_next = state;
      case (state)
         S_IDLE:      if (capture && (op_read || op_write)) state_next = S_ADDR_LO;
         S_ADDR_LO:   if (capture) state_next = S_ADDR_HI;
         S_ADDR_HI:   if (capture) state_next = cmd_read ? S_ISSUE : S_DATA;
         S_DATA:      if (capture) state_next = S_ISSUE;
         S_ISSUE:     state_next = S_WAIT_DONE;
         S_WAIT_DONE: if (cycle_done || timeout_hit) state_next = S_IDLE;
         default:     state_next = S_IDLE;
      endcase
   end

   always_comb begin
      host_busy = (state == S_ISSUE) || (state == S_WAIT_DONE);
      state_dbg = state;
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         strobe_s1     <= 1'b0;
         strobe_s2     <= 1'b0;
         strobe_d      <= 1'b0;
         host_ack      <= 1'b0;
         host_data_out <= 8'h00;
         error         <= 1'b0;
         control_out   <= 8'h00;
         address_out   <= '0;
         data_out      <= 8'h00;
         cmd_read      <= 1'b0;
         timeout_cnt   <= 8'h00;
      end else begin
         strobe_s1 <= host_strobe;
         strobe_s2 <= strobe_s1;
         strobe_d  <= strobe_s2;

         // Edges seen while busy are swallowed, so they never raise host_ack.
         if (capture)         host_ack <= 1'b1;
         else if (!strobe_s2) host_ack <= 1'b0;

         case (state)
            S_IDLE: begin
               if (capture) begin
                  if (op_read || op_write)       cmd_read <= op_read;
                  else if (host_data_in == 8'h80) error   <= 1'b0;
               end
            end
            S_ADDR_LO: if (capture) address_out[7:0] <= host_data_in;
            S_ADDR_HI: if (capture) address_out[ADDR_WIDTH-1:8] <= host_data_in[ADDR_WIDTH-9:0];
            S_DATA:    if (capture) data_out <= host_data_in;
            S_ISSUE: begin
               control_out <= cmd_read ? 8'h01 : 8'h02;
               timeout_cnt <= 8'h00;
            end
            S_WAIT_DONE: begin
               if (!data_read_n) host_data_out <= bus_data_in;
               if (cycle_done) begin
                  control_out <= 8'h00;
               end else if (timeout_hit) begin
                  control_out <= 8'h00;
                  error       <= 1'b1;
                  if (cmd_read) host_data_out <= 8'hFF;
               end else begin
                  timeout_cnt <= timeout_cnt + 8'h01;
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_isa_host_cmd.sv
// Bench for isa_host_cmd: drives host byte commands and a model sequencer, checking
// outputs against a high-level model of the command registers.
module tb_isa_host_cmd;

   localparam int AW = 10;
   localparam int TO = 255;

   logic          clk = 1'b0;
   logic          reset;
   logic [7:0]    host_data_in;
   logic          host_strobe;
   logic          host_ack;
   logic          host_busy;
   logic [7:0]    host_data_out;
   logic          error;
   logic [7:0]    control_out;
   logic [AW-1:0] address_out;
   logic [7:0]    data_out;
   logic [7:0]    bus_data_in;
   logic          data_read_n;
   logic          control_reset_n;
   logic [2:0]    state_dbg;

   int vectors = 0;
   int miscompares = 0;
   int cyc = 0;
   int req_cyc = 0;
   int ack_cyc = 0;
   logic [7:0] prev_ctrl = 8'h00;

   // Reference model of the host-visible registers
   logic [AW-1:0] exp_addr;
   logic [7:0]    exp_data;
   logic [7:0]    exp_hdo;
   logic          exp_err;

   isa_host_cmd #(.ADDR_WIDTH(AW), .TIMEOUT_CYCLES(TO)) dut (
      .clk(clk), .reset(reset), .host_data_in(host_data_in), .host_strobe(host_strobe),
      .host_ack(host_ack), .host_busy(host_busy), .host_data_out(host_data_out),
      .error(error), .control_out(control_out), .address_out(address_out),
      .data_out(data_out), .bus_data_in(bus_data_in), .data_read_n(data_read_n),
      .control_reset_n(control_reset_n), .state_dbg(state_dbg)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   always @(negedge clk) begin
      if (control_out != 8'h00 && prev_ctrl == 8'h00) req_cyc <= cyc;
      prev_ctrl <= control_out;
   end

   task automatic send_byte(input logic [7:0] b);
      int n;
      n = 0;
      while (host_ack !== 1'b0 && n < 8) begin @(negedge clk); n++; end
      host_data_in = b;
      host_strobe  = 1'b1;
      n = 0;
      do begin @(negedge clk); n++; end while (host_ack !== 1'b1 && n < 8);
      vectors++;
      if (host_ack !== 1'b1) begin
         miscompares++;
         $display("FAIL byte_ack byte=%h got ack=%b want 1", b, host_ack);
      end
      ack_cyc = cyc;
      host_strobe = 1'b0;
      n = 0;
      do begin @(negedge clk); n++; end while (host_ack !== 1'b0 && n < 8);
      vectors++;
      if (host_ack !== 1'b0) begin
         miscompares++;
         $display("FAIL ack_release byte=%h got ack=%b want 0", b, host_ack);
      end
   endtask

   task automatic send_cmd(input logic is_read, input logic [7:0] lo, input logic [7:0] hi,
                           input logic [7:0] wd);
      send_byte(is_read ? 8'h01 : 8'h02);
      send_byte(lo);
      send_byte(hi);
      exp_addr = AW'({hi, lo} & ((1 << AW) - 1));
      if (!is_read) begin
         send_byte(wd);
         exp_data = wd;
      end
   endtask

   // Sequencer model: holds the request dly cycles, pulses data_read_n n_rd times
   // on a read, then ends the cycle with a one-cycle control_reset_n pulse.
   task automatic run_seq(input logic is_read, input int dly, input int n_rd,
                          input logic [7:0] rd_base);
      int n;
      logic [7:0] want;
      want = is_read ? 8'h01 : 8'h02;
      n = 0;
      while (control_out === 8'h00 && n < 10) begin @(negedge clk); n++; end
      vectors++;
      if (control_out !== want || host_busy !== 1'b1) begin
         miscompares++;
         $display("FAIL request got ctrl=%h busy=%b want ctrl=%h busy=1", control_out, host_busy, want);
      end
      vectors++;
      if (address_out !== exp_addr || data_out !== exp_data) begin
         miscompares++;
         $display("FAIL latched got addr=%h data=%h want addr=%h data=%h",
                  address_out, data_out, exp_addr, exp_data);
      end
      for (int i = 0; i < dly; i++) begin
         @(negedge clk);
         vectors++;
         if (control_out !== want || host_busy !== 1'b1) begin
            miscompares++;
            $display("FAIL hold got ctrl=%h busy=%b want ctrl=%h busy=1", control_out, host_busy, want);
         end
         bus_data_in = 8'($urandom);
         if (is_read && i < n_rd) begin
            data_read_n = 1'b0;
            bus_data_in = rd_base + 8'(i);
            exp_hdo     = bus_data_in;
         end else begin
            data_read_n = 1'b1;
         end
      end
      @(negedge clk);
      data_read_n     = 1'b1;
      control_reset_n = 1'b0;
      @(negedge clk);
      control_reset_n = 1'b1;
      vectors++;
      if (control_out !== 8'h00 || host_busy !== 1'b0 || state_dbg !== 3'd0) begin
         miscompares++;
         $display("FAIL end_cycle got ctrl=%h busy=%b st=%0d want ctrl=00 busy=0 st=0",
                  control_out, host_busy, state_dbg);
      end
      vectors++;
      if (host_data_out !== exp_hdo || error !== exp_err) begin
         miscompares++;
         $display("FAIL result got hdo=%h err=%b want hdo=%h err=%b",
                  host_data_out, error, exp_hdo, exp_err);
      end
   endtask

   task automatic check_all_zero(input string tag);
      vectors++;
      if (host_ack !== 1'b0 || host_busy !== 1'b0 || host_data_out !== 8'h00 || error !== 1'b0 ||
          control_out !== 8'h00 || address_out !== '0 || data_out !== 8'h00 || state_dbg !== 3'd0) begin
         miscompares++;
         $display("FAIL %s got ack=%b busy=%b hdo=%h err=%b ctrl=%h addr=%h data=%h st=%0d want all 0",
                  tag, host_ack, host_busy, host_data_out, error, control_out, address_out, data_out, state_dbg);
      end
   endtask

   task automatic model_reset();
      exp_addr = '0;
      exp_data = 8'h00;
      exp_hdo  = 8'h00;
      exp_err  = 1'b0;
   endtask

   task automatic test_reset();
      reset = 1'b0;
      repeat (3) @(negedge clk);
      model_reset();
      check_all_zero("reset_state");
      reset = 1'b1;
      @(negedge clk);
   endtask

   task automatic test_write();
      send_cmd(1'b0, 8'h20, 8'h02, 8'hA5);
      vectors++;
      if (req_cyc !== ack_cyc + 1) begin
         miscompares++;
         $display("FAIL req_latency got %0d want %0d", req_cyc - ack_cyc, 1);
      end
      vectors++;
      if (address_out !== 10'h220 || data_out !== 8'hA5) begin
         miscompares++;
         $display("FAIL write_regs got addr=%h data=%h want addr=220 data=a5", address_out, data_out);
      end
      run_seq(1'b0, 6, 0, 8'h00);
   endtask

   task automatic test_read();
      send_cmd(1'b1, 8'h2A, 8'h02, 8'h00);
      run_seq(1'b1, 6, 1, 8'h5C);
      vectors++;
      if (host_data_out !== 8'h5C || address_out !== 10'h22A) begin
         miscompares++;
         $display("FAIL read_result got hdo=%h addr=%h want hdo=5c addr=22a", host_data_out, address_out);
      end
   endtask

   task automatic test_timeout();
      int n;
      send_cmd(1'b1, 8'($urandom), 8'($urandom), 8'h00);
      n = 0;
      while (control_out !== 8'h00 && n < TO + 40) begin @(negedge clk); n++; end
      exp_err = 1'b1;
      exp_hdo = 8'hFF;
      vectors++;
      if (cyc - req_cyc !== TO) begin
         miscompares++;
         $display("FAIL timeout_len got %0d want %0d", cyc - req_cyc, TO);
      end
      vectors++;
      if (control_out !== 8'h00 || error !== exp_err || host_data_out !== exp_hdo || host_busy !== 1'b0) begin
         miscompares++;
         $display("FAIL timeout_state got ctrl=%h err=%b hdo=%h busy=%b want ctrl=00 err=1 hdo=ff busy=0",
                  control_out, error, host_data_out, host_busy);
      end
      send_byte(8'h80);
      exp_err = 1'b0;
      vectors++;
      if (error !== exp_err) begin
         miscompares++;
         $display("FAIL error_clear got err=%b want 0", error);
      end
   endtask

   // Strobe held 10 cycles with an unknown opcode: one ack, no activity.
   task automatic test_handshake();
      int rises;
      logic prev;
      rises = 0;
      prev  = host_ack;
      host_data_in = 8'h33;
      host_strobe  = 1'b1;
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         if (host_ack === 1'b1 && prev !== 1'b1) rises++;
         prev = host_ack;
         if (i >= 3) begin
            vectors++;
            if (host_ack !== 1'b1 || control_out !== 8'h00 || state_dbg !== 3'd0) begin
               miscompares++;
               $display("FAIL hold_strobe cyc%0d got ack=%b ctrl=%h st=%0d want ack=1 ctrl=00 st=0",
                        i, host_ack, control_out, state_dbg);
            end
         end
      end
      vectors++;
      if (rises !== 1) begin
         miscompares++;
         $display("FAIL ack_count got %0d want 1", rises);
      end
      host_strobe = 1'b0;
      @(negedge clk);
      vectors++;
      if (host_ack !== 1'b1) begin
         miscompares++;
         $display("FAIL ack_after_fall got %b want 1", host_ack);
      end
      repeat (4) @(negedge clk);
      vectors++;
      if (host_ack !== 1'b0 || address_out !== exp_addr || control_out !== 8'h00) begin
         miscompares++;
         $display("FAIL ignored_op got ack=%b addr=%h ctrl=%h want ack=0 addr=%h ctrl=00",
                  host_ack, address_out, control_out, exp_addr);
      end
   endtask

   task automatic test_busy_drop();
      send_cmd(1'b1, 8'($urandom), 8'($urandom), 8'h00);
      host_data_in = 8'h02;
      host_strobe  = 1'b1;
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         if (i == 5) host_strobe = 1'b0;
         vectors++;
         if (host_ack !== 1'b0 || host_busy !== 1'b1) begin
            miscompares++;
            $display("FAIL busy_drop cyc%0d got ack=%b busy=%b want ack=0 busy=1", i, host_ack, host_busy);
         end
      end
      run_seq(1'b1, 3, 2, 8'($urandom));
   endtask

   task automatic test_reset_mid();
      send_cmd(1'b0, 8'($urandom), 8'($urandom), 8'($urandom));
      repeat (2) @(negedge clk);
      reset = 1'b0;
      @(negedge clk);
      model_reset();
      check_all_zero("reset_mid");
      reset = 1'b1;
      @(negedge clk);
      send_cmd(1'b0, 8'h5A, 8'h01, 8'h3C);
      run_seq(1'b0, 4, 0, 8'h00);
   endtask

   task automatic test_back_to_back();
      for (int k = 0; k < 20; k++) begin
         logic is_read;
         int   dly;
         is_read = 1'($urandom_range(0, 1));
         dly     = $urandom_range(2, 12);
         send_cmd(is_read, 8'($urandom), 8'($urandom), 8'($urandom));
         run_seq(is_read, dly, $urandom_range(1, dly), 8'($urandom));
      end
   endtask

   initial begin
      reset           = 1'b0;
      host_data_in    = 8'h00;
      host_strobe     = 1'b0;
      bus_data_in     = 8'h00;
      data_read_n     = 1'b1;
      control_reset_n = 1'b1;
      model_reset();
      @(negedge clk);
      test_reset();
      test_write();
      test_read();
      test_timeout();
      test_handshake();
      test_busy_drop();
      test_reset_mid();
      test_back_to_back();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
